// File: rtl/ext_stream_pkg.sv
// Shared types for the external streaming front end of the matrix multiplier.
package ext_stream_pkg;

    typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, DRAIN} state_e;

    // A counter for n beats needs at least one bit, even when n is 1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ext_stream_ctrl_if.sv
// Host-side streaming channels: weight rows in, input vectors in, result vectors out.
interface ext_stream_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int ROW   = 4,
    parameter int COL   = 4
);
    logic                 w_valid_i;
    logic                 w_ready_o;
    logic [COL*WIDTH-1:0] w_data_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [ROW*WIDTH-1:0] in_data_i;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic [COL*WIDTH-1:0] res_data_o;
    logic                 res_last_o;

    modport slave (
        input  w_valid_i, w_data_i, in_valid_i, in_data_i, res_ready_i,
        output w_ready_o, in_ready_o, res_valid_o, res_data_o, res_last_o
    );

    modport master (
        output w_valid_i, w_data_i, in_valid_i, in_data_i, res_ready_i,
        input  w_ready_o, in_ready_o, res_valid_o, res_data_o, res_last_o
    );
endinterface

// File: rtl/ext_res_fifo.sv
// Result FIFO with synchronous flush; the head reads as zero while empty.
module ext_res_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count define validity,
    // and the empty gate on rdata keeps stale contents off the output.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Credits upstream guarantee a free slot for every push.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i || flush)
        !(push && full && !pop));

endmodule

// File: rtl/ext_stream_ctrl.sv
// Streaming front end: loads ROW weight rows, streams input tiles into the systolic
// array, and queues results in a credit-protected FIFO.
module ext_stream_ctrl
    import ext_stream_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int ROW         = 4,
    parameter int COL         = 4,
    parameter int OFIFO_DEPTH = 4,
    parameter int RES_LAT     = 1,
    parameter int TILE_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 go_i,
    input  logic                 abort_i,
    input  logic [TILE_W-1:0]    cfg_tiles_i,
    ext_stream_ctrl_if.slave     host,
    output logic [COL*WIDTH-1:0] sa_north_o,
    output logic [ROW*WIDTH-1:0] sa_west_o,
    output logic                 sa_load_o,
    output logic                 sa_sum_out_o,
    input  logic [COL*WIDTH-1:0] sa_south_i,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int BEAT_W = cnt_w(ROW);
    localparam int CNT_W  = $clog2(OFIFO_DEPTH) + 1;

    state_e              state;
    logic [BEAT_W-1:0]   w_cnt, beat_cnt;
    logic [TILE_W-1:0]   tile_cnt, tiles_q, tile_nxt;
    logic [CNT_W-1:0]    reserved, fifo_count;
    logic [CNT_W:0]      occupancy;
    logic [RES_LAT-1:0]  pipe_vld, pipe_last;
    logic                fifo_full, fifo_empty, push, pop;
    logic                first_beat, last_beat, final_tile, credit_ok, w_fire, in_fire;

    // A tile may only start if its result already has a guaranteed FIFO slot.
    assign occupancy  = {1'b0, fifo_count} + {1'b0, reserved};
    assign credit_ok  = !fifo_full && (occupancy < (CNT_W+1)'(OFIFO_DEPTH));
    assign first_beat = (beat_cnt == '0);
    assign last_beat  = (beat_cnt == BEAT_W'(ROW - 1));
    assign tile_nxt   = tile_cnt + 1'b1;
    assign final_tile = (tile_nxt == tiles_q);

    assign host.w_ready_o  = (state == LOAD_W) && !abort_i;
    assign host.in_ready_o = (state == COMPUTE) && !abort_i && (!first_beat || credit_ok);
    assign w_fire          = host.w_ready_o && host.w_valid_i;
    assign in_fire         = host.in_ready_o && host.in_valid_i;

    assign sa_load_o    = w_fire;
    assign sa_north_o   = w_fire ? host.w_data_i : '0;
    assign sa_sum_out_o = in_fire;
    assign sa_west_o    = in_fire ? host.in_data_i : '0;

    assign push             = pipe_vld[RES_LAT-1];
    assign pop              = host.res_valid_o && host.res_ready_i;
    assign host.res_valid_o = !fifo_empty;
    assign busy_o           = (state != IDLE);

    ext_res_fifo #(.WIDTH(COL*WIDTH + 1), .DEPTH(OFIFO_DEPTH)) u_res_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .flush  (abort_i),
        .push   (push),
        .pop    (pop),
        .wdata  ({pipe_last[RES_LAT-1], sa_south_i}),
        .rdata  ({host.res_last_o, host.res_data_o}),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // NOTE: every register here uses non-blocking assignment so all updates
    // see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            w_cnt     <= '0;
            beat_cnt  <= '0;
            tile_cnt  <= '0;
            tiles_q   <= '0;
            reserved  <= '0;
            pipe_vld  <= '0;
            pipe_last <= '0;
            done_o    <= 1'b0;
        end else if (abort_i) begin
            state     <= IDLE;
            w_cnt     <= '0;
            beat_cnt  <= '0;
            tile_cnt  <= '0;
            reserved  <= '0;
            pipe_vld  <= '0;
            pipe_last <= '0;
            done_o    <= 1'b0;
        end else begin
            done_o       <= 1'b0;
            pipe_vld[0]  <= in_fire && last_beat;
            pipe_last[0] <= in_fire && last_beat && final_tile;
            for (int i = 1; i < RES_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end

            case ({in_fire && first_beat, push})
                2'b10:   reserved <= reserved + 1'b1;
                2'b01:   reserved <= reserved - 1'b1;
                default: ;
            endcase

            case (state)
                IDLE: begin
                    if (go_i && cfg_tiles_i != '0) begin
                        tiles_q  <= cfg_tiles_i;
                        w_cnt    <= '0;
                        beat_cnt <= '0;
                        tile_cnt <= '0;
                        state    <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (w_fire) begin
                        if (w_cnt == BEAT_W'(ROW - 1)) begin
                            w_cnt <= '0;
                            state <= COMPUTE;
                        end else begin
                            w_cnt <= w_cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (in_fire) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            tile_cnt <= tile_nxt;
                            if (final_tile) state <= DRAIN;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_vld == '0 && fifo_empty) begin
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_stream_ctrl.sv
// Directed bench for ext_stream_ctrl: a cycle table for the basic run plus
// sequences for backpressure, bubbles, abort, ignored starts and async reset.
module tb_ext_stream_ctrl;
    localparam int WIDTH = 8, ROW = 4, COL = 4, DEPTH = 4, RES_LAT = 1, TILE_W = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        go, abort;
    logic [15:0] cfg_tiles;
    logic [31:0] sa_north, sa_west, sa_south;
    logic        sa_load, sa_sum, busy, done;

    ext_stream_ctrl_if #(.WIDTH(WIDTH), .ROW(ROW), .COL(COL)) bus ();

    ext_stream_ctrl #(
        .WIDTH(WIDTH), .ROW(ROW), .COL(COL), .OFIFO_DEPTH(DEPTH),
        .RES_LAT(RES_LAT), .TILE_W(TILE_W)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .go_i(go), .abort_i(abort), .cfg_tiles_i(cfg_tiles),
        .host(bus), .sa_north_o(sa_north), .sa_west_o(sa_west), .sa_load_o(sa_load),
        .sa_sum_out_o(sa_sum), .sa_south_i(sa_south), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Expected flag order: {busy, done, w_ready, in_ready, load, sum, res_valid, res_last}
    typedef struct {
        logic        go;
        logic [15:0] tiles;
        logic        w_valid;
        logic [31:0] w_data;
        logic        in_valid;
        logic [31:0] in_data;
        logic        res_ready;
        logic [31:0] south;
        logic [7:0]  exp_flags;
        logic [31:0] exp_north;
        logic [31:0] exp_west;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] flags();
        return {busy, done, bus.w_ready_o, bus.in_ready_o, sa_load, sa_sum,
                bus.res_valid_o, bus.res_last_o};
    endfunction

    task automatic idle_inputs();
        go = 0; abort = 0; cfg_tiles = '0; sa_south = '0;
        bus.w_valid_i = 0; bus.w_data_i = '0; bus.in_valid_i = 0; bus.in_data_i = '0;
        bus.res_ready_i = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rstn = 0;
        #1;
        check("reset flags", flags(), 8'h00);
        check("reset res_data", bus.res_data_o, 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1;
    endtask

    // Streams n tiles end to end. hold: cycles with res_ready low; bubble: in_valid every other cycle.
    task automatic run_tiles(input int n, input bit go_noise, input int hold, input bit bubble,
                             input string tag);
        int beats, got;
        bit pend, seen_done;
        logic [31:0] pval;
        beats = 0; got = 0; pend = 0; seen_done = 0; pval = '0;
        @(negedge clk);
        go = 1; cfg_tiles = 16'(n);
        for (int k = 0; k < ROW; k++) begin
            @(negedge clk);
            go = go_noise; cfg_tiles = 16'd7;
            bus.w_valid_i = 1; bus.w_data_i = 32'hC0DE_0000 + k;
            #1;
            check($sformatf("%s load%0d", tag, k), {sa_load, sa_north}, {1'b1, 32'hC0DE_0000 + k});
        end
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            @(negedge clk);
            bus.w_valid_i   = 0;
            sa_south        = pend ? pval : 32'hDEAD_BEEF;
            pend            = 0;
            bus.in_valid_i  = (beats < n * ROW) && (!bubble || (cyc % 2 == 0));
            bus.in_data_i   = 32'h0100_0000 + beats;
            bus.res_ready_i = (cyc >= hold);
            if (beats >= n * ROW) go = 0;
            #1;
            if (bubble) begin
                check($sformatf("%s sum c%0d", tag, cyc), sa_sum, bus.in_valid_i);
                check($sformatf("%s west c%0d", tag, cyc), sa_west,
                      bus.in_valid_i ? bus.in_data_i : 32'h0);
            end
            if (hold > 0 && cyc == hold - 1) begin
                check({tag, " beats held"}, beats, (n < DEPTH ? n : DEPTH) * ROW);
                check({tag, " in_ready held"}, bus.in_ready_o, 1'b0);
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                beats++;
                if (beats % ROW == 0) begin
                    pend = 1;
                    pval = 32'h5A00_0000 + beats / ROW;
                end
            end
            if (bus.res_valid_o && bus.res_ready_i) begin
                got++;
                check($sformatf("%s res%0d data", tag, got), bus.res_data_o, 32'h5A00_0000 + got);
                check($sformatf("%s res%0d last", tag, got), bus.res_last_o, got == n);
            end
            if (done) begin
                seen_done = 1;
                check({tag, " busy at done"}, busy, 1'b0);
            end
        end
        check({tag, " result count"}, got, n);
        check({tag, " done seen"}, seen_done, 1'b1);
        idle_inputs();
    endtask

    initial begin
        reset_dut();

        // go, tiles, w_valid, w_data, in_valid, in_data, res_ready, south, flags, north, west, res
        vecs[0]  = '{1, 16'd1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         8'h00, 32'h0,         32'h0,         32'h0};
        vecs[1]  = '{0, 16'd0, 1, 32'h1111_1111, 0, 32'h0,         0, 32'h0,         8'hA8, 32'h1111_1111, 32'h0,         32'h0};
        vecs[2]  = '{0, 16'd0, 1, 32'h2222_2222, 0, 32'h0,         0, 32'h0,         8'hA8, 32'h2222_2222, 32'h0,         32'h0};
        vecs[3]  = '{0, 16'd0, 1, 32'h3333_3333, 0, 32'h0,         0, 32'h0,         8'hA8, 32'h3333_3333, 32'h0,         32'h0};
        vecs[4]  = '{0, 16'd0, 1, 32'h4444_4444, 0, 32'h0,         0, 32'h0,         8'hA8, 32'h4444_4444, 32'h0,         32'h0};
        vecs[5]  = '{0, 16'd0, 0, 32'h0,         1, 32'h0102_0304, 0, 32'h0,         8'h94, 32'h0,         32'h0102_0304, 32'h0};
        vecs[6]  = '{0, 16'd0, 0, 32'h0,         1, 32'h0506_0708, 0, 32'h0,         8'h94, 32'h0,         32'h0506_0708, 32'h0};
        vecs[7]  = '{0, 16'd0, 0, 32'h0,         1, 32'h090A_0B0C, 0, 32'h0,         8'h94, 32'h0,         32'h090A_0B0C, 32'h0};
        vecs[8]  = '{0, 16'd0, 0, 32'h0,         1, 32'h0D0E_0F10, 0, 32'h0,         8'h94, 32'h0,         32'h0D0E_0F10, 32'h0};
        vecs[9]  = '{0, 16'd0, 0, 32'h0,         1, 32'h0BAD_0BAD, 0, 32'h0403_0201, 8'h80, 32'h0,         32'h0,         32'h0};
        vecs[10] = '{0, 16'd0, 0, 32'h0,         0, 32'h0,         0, 32'hFFFF_FFFF, 8'h83, 32'h0,         32'h0,         32'h0403_0201};
        vecs[11] = '{0, 16'd0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         8'h83, 32'h0,         32'h0,         32'h0403_0201};
        vecs[12] = '{0, 16'd0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         8'h80, 32'h0,         32'h0,         32'h0};
        vecs[13] = '{0, 16'd0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         8'h40, 32'h0,         32'h0,         32'h0};
        vecs[14] = '{0, 16'd0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         8'h00, 32'h0,         32'h0,         32'h0};

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            go = vecs[i].go; cfg_tiles = vecs[i].tiles;
            bus.w_valid_i = vecs[i].w_valid; bus.w_data_i = vecs[i].w_data;
            bus.in_valid_i = vecs[i].in_valid; bus.in_data_i = vecs[i].in_data;
            bus.res_ready_i = vecs[i].res_ready; sa_south = vecs[i].south;
            #1;
            check($sformatf("vec%0d flags", i), flags(), vecs[i].exp_flags);
            check($sformatf("vec%0d north", i), sa_north, vecs[i].exp_north);
            check($sformatf("vec%0d west", i), sa_west, vecs[i].exp_west);
            check($sformatf("vec%0d res_data", i), bus.res_data_o, vecs[i].exp_res);
        end
        idle_inputs();

        run_tiles(6, 0, 40, 0, "backpressure");
        run_tiles(1, 0, 0, 1, "bubbles");

        // Abort at beat 2 of the second tile with one result queued.
        @(negedge clk); go = 1; cfg_tiles = 16'd3;
        for (int k = 0; k < ROW; k++) begin
            @(negedge clk); go = 0; bus.w_valid_i = 1; bus.w_data_i = 32'h00AA_0000 + k;
        end
        for (int k = 0; k < ROW; k++) begin
            @(negedge clk); bus.w_valid_i = 0; bus.in_valid_i = 1; bus.in_data_i = 32'h0000_0010 + k;
        end
        @(negedge clk); bus.in_valid_i = 0; sa_south = 32'hABCD_0001;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); sa_south = '0; bus.in_valid_i = 1; bus.in_data_i = 32'h0000_0020 + k;
        end
        #1;
        check("abort queued valid", bus.res_valid_o, 1'b1);
        check("abort queued data", bus.res_data_o, 32'hABCD_0001);
        @(negedge clk); abort = 1; go = 1; cfg_tiles = 16'd5; bus.in_valid_i = 1;
        #1;
        check("abort cycle in_ready", bus.in_ready_o, 1'b0);
        check("abort cycle sum", sa_sum, 1'b0);
        @(negedge clk); idle_inputs();
        #1;
        check("after abort flags", flags(), 8'h00);
        check("after abort res_data", bus.res_data_o, 32'h0);
        @(negedge clk); #1;
        check("after abort no done", flags(), 8'h00);
        run_tiles(1, 0, 0, 0, "post_abort");

        // go with zero tiles is ignored; go during the run is ignored.
        @(negedge clk); go = 1; cfg_tiles = 16'd0;
        @(negedge clk); go = 0; #1;
        check("zero tiles idle", {busy, bus.w_ready_o}, 2'b00);
        run_tiles(2, 1, 0, 0, "go_noise");

        // Asynchronous reset in the middle of COMPUTE.
        @(negedge clk); go = 1; cfg_tiles = 16'd3;
        for (int k = 0; k < ROW; k++) begin
            @(negedge clk); go = 0; bus.w_valid_i = 1; bus.w_data_i = 32'h00BB_0000 + k;
        end
        @(negedge clk); bus.w_valid_i = 0; bus.in_valid_i = 1; bus.in_data_i = 32'h77;
        #1;
        check("pre-reset sum", sa_sum, 1'b1);
        @(negedge clk); bus.in_valid_i = 1; bus.in_data_i = 32'h78;
        #1; rstn = 0; #1;
        check("async reset flags", flags(), 8'h00);
        check("async reset west", sa_west, 32'h0);
        idle_inputs();
        @(negedge clk); rstn = 1;
        run_tiles(1, 0, 0, 0, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
